// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter feeding the mux21 datapath.
package rr_mux_arbiter_pkg;

    // Default sizing: the data width matches the 8-bit adder datapath.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    // mux21 select encoding.
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // Last-grant pointer. Its encoding matches the select of the channel last
    // served, so resetting to LAST2 hands the first contended grant to channel 1.
    typedef enum logic {
        LAST1 = 1'b0,
        LAST2 = 1'b1
    } last_e;

endpackage

// File: rtl/rr_mux_arbiter_mux21.sv
// Single-bit 2:1 multiplexor. select=0 passes input1 and select=1 passes input2.
module mux21 (
    input  logic input1,
    input  logic input2,
    input  logic select,
    output logic out
);

    assign out = select ? input2 : input1;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for two valid/ready producers. It drives the mux21 select,
// registers the chosen word into a one-entry output buffer, and counts the
// transfers accepted from each channel.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid1,
    input  logic [WIDTH-1:0] input1,
    output logic             ready1,
    input  logic             valid2,
    input  logic [WIDTH-1:0] input2,
    output logic             ready2,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2
);

    logic             accept;
    logic             grant_sel;
    logic             xfer1;
    logic             xfer2;
    logic [WIDTH-1:0] mux_out;

    logic             sel_q,       sel_d;
    last_e            last_q,      last_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic [CNT_W-1:0] count1_q,    count1_d;
    logic [CNT_W-1:0] count2_q,    count2_d;

    // Datapath: one mux21 per data bit, all steered by the current grant.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux21 u_mux21 (
            .input1 (input1[i]),
            .input2 (input2[i]),
            .select (grant_sel),
            .out    (mux_out[i])
        );
    end

    // Grant: a lone requester wins, contention goes to the channel not served
    // last, and with no requester the previous select is held.
    // NOTE: assigning every always_comb output a default first means no path
    // leaves it unassigned, so no latch is inferred.
    always_comb begin
        grant_sel = sel_q;
        if (valid1 && valid2) begin
            grant_sel = (last_q == LAST1) ? SEL_IN2 : SEL_IN1;
        end else if (valid1) begin
            grant_sel = SEL_IN1;
        end else if (valid2) begin
            grant_sel = SEL_IN2;
        end
    end

    // The buffer takes a word when it is empty or draining in this same cycle.
    // The handshake is blocked during reset so nothing is counted on that edge.
    assign accept = !out_valid_q || out_ready;
    assign ready1 = !reset && accept && valid1 && (grant_sel == SEL_IN1);
    assign ready2 = !reset && accept && valid2 && (grant_sel == SEL_IN2);
    assign xfer1  = valid1 && ready1;
    assign xfer2  = valid2 && ready2;

    // Next state: refill on a transfer, drain when the consumer takes the word
    // without a refill, and otherwise hold the buffer.
    always_comb begin
        sel_d       = grant_sel;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        count1_d    = count1_q;
        count2_d    = count2_q;
        if (xfer1 || xfer2) begin
            out_d       = mux_out;
            out_valid_d = 1'b1;
            last_d      = xfer2 ? LAST2 : LAST1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer1) begin
            count1_d = count1_q + CNT_W'(1);
        end
        if (xfer2) begin
            count2_d = count2_q + CNT_W'(1);
        end
    end

    // State registers. Reset is synchronous and discards any buffered word.
    // NOTE: non-blocking assignments make every register sample the values
    // from before the edge, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= SEL_IN1;
            last_q      <= LAST2;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            count1_q    <= '0;
            count2_q    <= '0;
        end else begin
            sel_q       <= sel_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            count1_q    <= count1_d;
            count2_q    <= count2_d;
        end
    end

    assign select    = grant_sel;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign count1    = count1_q;
    assign count2    = count2_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter. Expected values are worked out by hand.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid1;
    logic [WIDTH-1:0] input1;
    logic             ready1;
    logic             valid2;
    logic [WIDTH-1:0] input2;
    logic             ready2;
    logic             select;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             out_ready;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid1    (valid1),
        .input1    (input1),
        .ready1    (ready1),
        .valid2    (valid2),
        .input2    (input2),
        .ready2    (ready2),
        .select    (select),
        .out_valid (out_valid),
        .out       (out),
        .out_ready (out_ready),
        .count1    (count1),
        .count2    (count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cont_out [4];
        logic       cont_sel [4];
        cont_out = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
        cont_sel = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset then idle.
        reset = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
        input1 = '0; input2 = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_select",    select,    0);
        check("rst_ready1",    ready1,    0);
        check("rst_ready2",    ready2,    0);
        check("rst_count1",    count1,    0);
        check("rst_count2",    count2,    0);

        // Single-channel stream: 11, 22, 33 back to back.
        valid1 = 1'b1; out_ready = 1'b1;
        input1 = 8'h11; settle();
        check("s1_ready1", ready1, 1);
        check("s1_select", select, 0);
        tick();
        check("s1_out",   out,       8'h11);
        check("s1_valid", out_valid, 1);
        input1 = 8'h22; settle();
        check("s2_ready1", ready1, 1);
        tick();
        check("s2_out", out, 8'h22);
        input1 = 8'h33; settle();
        check("s3_select", select, 0);
        tick();
        check("s3_out",    out,    8'h33);
        check("s3_count1", count1, 3);
        valid1 = 1'b0; settle();
        check("idle_select_hold", select, 0);
        tick();
        check("drain_valid",    out_valid, 0);
        check("drain_out_hold", out,       8'h33);

        // Fresh reset so contention starts from the reset pointer.
        reset = 1'b1; tick(); reset = 1'b0;
        valid1 = 1'b1; valid2 = 1'b1; input1 = 8'hA1; input2 = 8'hB2; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("rr%0d_select", i), select, cont_sel[i]);
            check($sformatf("rr%0d_ready1", i), ready1, !cont_sel[i]);
            check($sformatf("rr%0d_ready2", i), ready2, cont_sel[i]);
            tick();
            check($sformatf("rr%0d_out", i), out, cont_out[i]);
        end
        check("rr_count1", count1, 2);
        check("rr_count2", count2, 2);
        valid1 = 1'b0; valid2 = 1'b0;
        tick();
        check("rr_drain_valid", out_valid, 0);

        // Back-pressure: fill with 5C, then stall channel 2 for three cycles.
        valid1 = 1'b1; input1 = 8'h5C; out_ready = 1'b0;
        tick();
        check("bp_fill_out",   out,       8'h5C);
        check("bp_fill_valid", out_valid, 1);
        valid1 = 1'b0; valid2 = 1'b1; input2 = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp%0d_ready1", i), ready1, 0);
            check($sformatf("bp%0d_ready2", i), ready2, 0);
            tick();
            check($sformatf("bp%0d_out", i),   out,       8'h5C);
            check($sformatf("bp%0d_valid", i), out_valid, 1);
        end
        out_ready = 1'b1; settle();
        check("bp_release_ready2", ready2, 1);
        check("bp_release_select", select, 1);
        tick();
        check("bp_release_out", out,    8'h7E);
        check("bp_count1",      count1, 3);
        check("bp_count2",      count2, 3);

        // Counter wrap: 256 more channel-2 transfers bring count2 back to 3.
        for (int i = 0; i < 252; i++) begin
            input2 = 8'(i);
            tick();
        end
        check("wrap_count2_ff", count2, 8'hFF);
        input2 = 8'hE0;
        tick();
        check("wrap_count2_00", count2, 8'h00);
        check("wrap_out",       out,    8'hE0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("wrap_count2_03", count2, 3);
        check("wrap_count1",    count1, 3);
        valid2 = 1'b0;
        tick();

        // Reset mid-operation: buffer holds C3 with count1 at 5.
        valid1 = 1'b1; input1 = 8'hC3; out_ready = 1'b1;
        tick();
        tick();
        valid1 = 1'b0; out_ready = 1'b0; settle();
        check("mid_out",    out,       8'hC3);
        check("mid_valid",  out_valid, 1);
        check("mid_count1", count1,    5);
        valid1 = 1'b1; out_ready = 1'b1; reset = 1'b1; settle();
        check("mid_rst_ready1", ready1, 0);
        tick();
        reset = 1'b0; valid1 = 1'b0;
        check("mid_rst_valid",  out_valid, 0);
        check("mid_rst_out",    out,       0);
        check("mid_rst_count1", count1,    0);
        check("mid_rst_count2", count2,    0);
        valid1 = 1'b1; valid2 = 1'b1; input1 = 8'hA1; input2 = 8'hB2; settle();
        check("post_rst_select", select, 0);
        check("post_rst_ready1", ready1, 1);
        tick();
        check("post_rst_out", out, 8'hA1);
        settle();
        check("post_rst_select2", select, 1);
        tick();
        check("post_rst_out2",   out,    8'hB2);
        check("post_rst_count1", count1, 1);
        check("post_rst_count2", count2, 1);
        valid1 = 1'b0; valid2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
